// File: rtl/hub75_pkg.sv
// hub75_pkg
// Shared definitions for the HUB75 panel scheduler:
//   - default geometry / timing parameters (COLS, ROWS, BITS, BASE)
//   - scheduler FSM state encoding (state_e)
package hub75_pkg;

  // Default panel geometry and BCM timing.
  localparam int COLS_DEF = 64;  // columns shifted per row
  localparam int ROWS_DEF = 16;  // scan rows per frame
  localparam int BITS_DEF = 8;   // BCM bit planes per colour
  localparam int BASE_DEF = 2;   // on-time clocks for the LSB plane

  // Scheduler states.
  //   IDLE      : panel dark, waiting for en
  //   SHIFT     : clocking one (row, plane) into the column drivers
  //   LATCH     : one-cycle latch pulse, panel dark
  //   ROW_SETUP : row-select token presented (plane 0 only)
  //   ROW_CLK   : row-select shift clock pulse (plane 0 only)
  //   DRAIN     : last display of a frame running, no further shift
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    LATCH     = 3'd2,
    ROW_SETUP = 3'd3,
    ROW_CLK   = 3'd4,
    DRAIN     = 3'd5
  } state_e;

endpackage

// File: rtl/hub75_bcm_timer.sv
// hub75_bcm_timer
// Binary-code-modulation on-time counter. A load starts a display window of
// BASE << plane_i cycles during which blank_o is 0; blank_o returns to 1 the
// cycle after the count expires.
// Ports:
//   clk_i, rst_i : clock, synchronous active-high reset
//   load_i       : start a display window (takes effect next cycle)
//   plane_i      : plane whose weight sets the window length
//   blank_o      : registered panel output-disable (1 = dark)
//   done_o       : display finished, or finishing in this cycle
module hub75_bcm_timer
  import hub75_pkg::*;
#(
  parameter int BITS = BITS_DEF,
  parameter int BASE = BASE_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    load_i,
  input  logic [$clog2(BITS)-1:0] plane_i,
  output logic                    blank_o,
  output logic                    done_o
);

  // Wide enough to hold the longest window length itself.
  localparam int CNT_W = $clog2(BASE << (BITS - 1)) + 1;

  logic [CNT_W-1:0] on_len;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blank_q, blank_d;

  always_comb begin
    on_len  = CNT_W'(BASE) << plane_i;
    cnt_d   = cnt_q;
    blank_d = blank_q;
    if (load_i) begin
      // cnt counts the remaining lit cycles after the current one.
      cnt_d   = on_len - CNT_W'(1);
      blank_d = 1'b0;
    end else if (!blank_q) begin
      if (cnt_q == '0) begin
        blank_d = 1'b1;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      blank_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      blank_q <= blank_d;
    end
  end

  assign blank_o = blank_q;
  // Counting as done in the last lit cycle lets the next latch follow
  // immediately after the window closes.
  assign done_o  = blank_q | (cnt_q == '0);

endmodule

// File: rtl/hub75_scheduler.sv
// hub75_scheduler
// Drives a HUB75 LED panel from a bit-plane framebuffer using binary code
// modulation. For every (row, plane) the columns are shifted out while the
// previously latched plane is displayed; a latch then transfers the new data,
// and on plane 0 the row-select shift register is advanced.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   en                : run request, sampled in IDLE and at the last latch of a frame
//   fb_row/col/plane  : framebuffer fetch address
//   fb_bits           : {r1,g1,b1,...,r4,g4,b4}, valid one cycle after the address
//   r1..b4            : panel colour data
//   clk_out, lat      : panel shift clock, latch
//   blank             : panel output-disable (1 = dark)
//   row_clk, row_data : row-select shift register clock and token
//   frame_sync        : one-cycle pulse in the latch cycle of row 0, plane 0
// Fetch contract: the framebuffer is a fixed-latency read port with no
// handshake; an address presented in cycle k must be answered on fb_bits in
// cycle k+1, where it is captured at the end of that cycle.
module hub75_scheduler
  import hub75_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int BITS = BITS_DEF,
  parameter int BASE = BASE_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [$clog2(ROWS)-1:0] fb_row,
  output logic [$clog2(COLS)-1:0] fb_col,
  output logic [$clog2(BITS)-1:0] fb_plane,
  input  logic [11:0]             fb_bits,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic                    r2,
  output logic                    g2,
  output logic                    b2,
  output logic                    r3,
  output logic                    g3,
  output logic                    b3,
  output logic                    r4,
  output logic                    g4,
  output logic                    b4,
  output logic                    clk_out,
  output logic                    lat,
  output logic                    blank,
  output logic                    row_clk,
  output logic                    row_data,
  output logic                    frame_sync
);

  localparam int RW        = $clog2(ROWS);
  localparam int CW        = $clog2(COLS);
  localparam int PW        = $clog2(BITS);
  localparam int SHIFT_LEN = 2 * COLS + 2;
  localparam int KW        = $clog2(SHIFT_LEN);

  // Shift-phase landmarks (k runs 0 .. SHIFT_LEN-1).
  localparam logic [KW-1:0] K_LAST      = KW'(SHIFT_LEN - 1);
  localparam logic [KW-1:0] K_COL_LAST  = KW'(2 * COLS - 3);  // last k that advances fb_col
  localparam logic [KW-1:0] K_DATA_LAST = KW'(2 * COLS - 1);  // last k that captures fb_bits
  localparam logic [KW-1:0] K_CLK_LAST  = KW'(2 * COLS);      // last k that schedules clk_out
  localparam logic [RW-1:0] ROW_LAST    = RW'(ROWS - 1);
  localparam logic [PW-1:0] PLANE_LAST  = PW'(BITS - 1);

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [RW-1:0]   fb_row_q;
  logic [CW-1:0]   fb_col_q;
  logic [PW-1:0]   fb_plane_q;
  logic [11:0]     rgb_q;
  logic            clk_out_q;
  logic            lat_q;
  logic            row_clk_q;
  logic            row_data_q;
  logic            frame_sync_q;
  logic            drain_q;

  logic [RW-1:0]   next_row;
  logic [PW-1:0]   next_plane;
  logic            col_step;
  logic            data_load;
  logic            clk_next;
  logic            drain_req;
  logic            disp_load;
  logic            disp_done;
  logic            timer_blank;

  // Next (row, plane) in scan order: planes fastest, rows wrap per frame.
  always_comb begin
    next_row   = fb_row_q;
    next_plane = fb_plane_q + PW'(1);
    if (fb_plane_q == PLANE_LAST) begin
      next_plane = '0;
      next_row   = (fb_row_q == ROW_LAST) ? '0 : fb_row_q + RW'(1);
    end
  end

  // Column c is addressed at k=2c, its bits arrive at k=2c+1 and are
  // captured for k=2c+2, and the panel clock rises at k=2c+3 with the data
  // already stable for a full cycle.
  assign col_step  = k_q[0] && (k_q <= K_COL_LAST);
  assign data_load = k_q[0] && (k_q <= K_DATA_LAST);
  assign clk_next  = !k_q[0] && (k_q >= KW'(2)) && (k_q <= K_CLK_LAST);

  // en only matters at the latch that closes a frame.
  assign drain_req = (fb_row_q == ROW_LAST) && (fb_plane_q == PLANE_LAST) && !en;

  // Display of the just-latched plane begins right after the latch, or after
  // the row-select clock when the row changes.
  assign disp_load = ((state_q == LATCH) && (fb_plane_q != '0)) || (state_q == ROW_CLK);

  hub75_bcm_timer #(
    .BITS (BITS),
    .BASE (BASE)
  ) u_bcm_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (disp_load),
    .plane_i (fb_plane_q),
    .blank_o (timer_blank),
    .done_o  (disp_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      k_q          <= '0;
      fb_row_q     <= '0;
      fb_col_q     <= '0;
      fb_plane_q   <= '0;
      rgb_q        <= '0;
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      row_clk_q    <= 1'b0;
      row_data_q   <= 1'b0;
      frame_sync_q <= 1'b0;
      drain_q      <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      clk_out_q    <= 1'b0;
      lat_q        <= 1'b0;
      row_clk_q    <= 1'b0;
      row_data_q   <= 1'b0;
      frame_sync_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (en) begin
            state_q    <= SHIFT;
            k_q        <= '0;
            fb_row_q   <= '0;
            fb_col_q   <= '0;
            fb_plane_q <= '0;
          end
        end

        SHIFT: begin
          if (data_load) rgb_q <= fb_bits;
          if (clk_next) clk_out_q <= 1'b1;
          if (k_q != K_LAST) begin
            k_q <= k_q + KW'(1);
            if (col_step) fb_col_q <= fb_col_q + CW'(1);
          end else if (disp_done) begin
            // Shift finished and the previous plane has had its full
            // on-time: safe to overwrite the output latches.
            state_q      <= LATCH;
            lat_q        <= 1'b1;
            frame_sync_q <= (fb_row_q == '0) && (fb_plane_q == '0);
          end
          // Otherwise k holds at K_LAST until the display window closes.
        end

        LATCH: begin
          drain_q <= drain_req;
          if (fb_plane_q == '0) begin
            // New row: inject the token only when returning to row 0.
            state_q    <= ROW_SETUP;
            row_data_q <= (fb_row_q == '0);
          end else if (drain_req) begin
            state_q <= DRAIN;
          end else begin
            state_q    <= SHIFT;
            k_q        <= '0;
            fb_col_q   <= '0;
            fb_row_q   <= next_row;
            fb_plane_q <= next_plane;
          end
        end

        ROW_SETUP: begin
          state_q    <= ROW_CLK;
          row_clk_q  <= 1'b1;
          row_data_q <= row_data_q;
        end

        ROW_CLK: begin
          if (drain_q) begin
            state_q <= DRAIN;
          end else begin
            state_q    <= SHIFT;
            k_q        <= '0;
            fb_col_q   <= '0;
            fb_row_q   <= next_row;
            fb_plane_q <= next_plane;
          end
        end

        DRAIN: begin
          if (disp_done) state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign fb_row     = fb_row_q;
  assign fb_col     = fb_col_q;
  assign fb_plane   = fb_plane_q;
  assign {r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4} = rgb_q;
  assign clk_out    = clk_out_q;
  assign lat        = lat_q;
  assign blank      = timer_blank;
  assign row_clk    = row_clk_q;
  assign row_data   = row_data_q;
  assign frame_sync = frame_sync_q;

endmodule

// File: tb/tb_hub75_scheduler.sv
// tb_hub75_scheduler
// Bench for hub75_scheduler at COLS=4, ROWS=2, BITS=2, BASE=2.
// Expected panel events (cycle number plus data) are queued when a run is
// started; a monitor pops and compares whenever the DUT raises an event.
module tb_hub75_scheduler;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int BITS = 2;
  localparam int BASE = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;
  int   cyc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // ---------------- DUT ----------------
  logic [0:0]  fb_row;
  logic [1:0]  fb_col;
  logic [0:0]  fb_plane;
  logic [11:0] fb_bits;
  logic r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4;
  logic clk_out, lat, blank, row_clk, row_data, frame_sync;
  logic [11:0] rgb;

  assign rgb = {r1, g1, b1, r2, g2, b2, r3, g3, b3, r4, g4, b4};

  hub75_scheduler #(
    .COLS (COLS),
    .ROWS (ROWS),
    .BITS (BITS),
    .BASE (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fb_row     (fb_row),
    .fb_col     (fb_col),
    .fb_plane   (fb_plane),
    .fb_bits    (fb_bits),
    .r1         (r1),
    .g1         (g1),
    .b1         (b1),
    .r2         (r2),
    .g2         (g2),
    .b2         (b2),
    .r3         (r3),
    .g3         (g3),
    .b3         (b3),
    .r4         (r4),
    .g4         (g4),
    .b4         (b4),
    .clk_out    (clk_out),
    .lat        (lat),
    .blank      (blank),
    .row_clk    (row_clk),
    .row_data   (row_data),
    .frame_sync (frame_sync)
  );

  // Directed framebuffer contents; (row 0, plane 0, col 0) is 12'hA5C.
  function automatic logic [11:0] pixel(input int r, input int p, input int c);
    return {4'hA ^ 4'(c), 4'h5 ^ 4'(p), 4'hC ^ 4'(r)};
  endfunction

  // Framebuffer read port with one cycle of latency.
  initial begin
    int pr, pp, pc;
    pr = 0; pp = 0; pc = 0;
    fb_bits = '0;
    forever begin
      @(negedge clk);
      fb_bits = pixel(pr, pp, pc);
      pr = int'(fb_row);
      pp = int'(fb_plane);
      pc = int'(fb_col);
    end
  end

  // ---------------- scoreboard ----------------
  // Entry format: {cycle[19:0], data[11:0]}
  logic [31:0] exp_lat_q[$];
  logic [31:0] exp_fs_q[$];
  logic [31:0] exp_clk_q[$];
  logic [31:0] exp_rc_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] exp_blk_q[$];

  int tests;
  int fails;
  bit mon_on;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_evt(input string name, input bit have, input logic [31:0] e,
                         input logic [11:0] act);
    tests++;
    if (!have) begin
      fails++;
      $display("FAIL %s: unexpected event at cycle %0d (data %h)", name, cyc, act);
    end else if (e[31:12] != 20'(cyc) || e[11:0] !== act) begin
      fails++;
      $display("FAIL %s: got cycle %0d data %h, expected cycle %0d data %h",
               name, cyc, act, e[31:12], e[11:0]);
    end
  endtask

  task automatic chk_empty(input string name, input int left, input logic [31:0] head);
    tests++;
    if (left != 0) begin
      fails++;
      $display("FAIL %s: %0d expected events never seen, next at cycle %0d", name, left, head[31:12]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_blank"},    12'(blank),      12'd1);
    chk({tag, "_lat"},      12'(lat),        12'd0);
    chk({tag, "_clk_out"},  12'(clk_out),    12'd0);
    chk({tag, "_row_clk"},  12'(row_clk),    12'd0);
    chk({tag, "_row_data"}, 12'(row_data),   12'd0);
    chk({tag, "_rgb"},      rgb,             12'h000);
    chk({tag, "_fsync"},    12'(frame_sync), 12'd0);
    chk({tag, "_fb_row"},   12'(fb_row),     12'd0);
    chk({tag, "_fb_col"},   12'(fb_col),     12'd0);
    chk({tag, "_fb_plane"}, 12'(fb_plane),   12'd0);
  endtask

  // Expected events for a run whose first SHIFT cycle is s, covering nblk
  // consecutive (row, plane) blocks, the last of which drains.
  // Per block starting at t: clk_out at t+3,5,7,9; lat at t+10; on plane 0
  // row_data at t+11..12, row_clk at t+12 and display from t+13, otherwise
  // display from t+11; display lasts BASE<<plane cycles and the next block's
  // shift starts with it.
  task automatic push_run(input int s, input int nblk);
    int t, d, row, pl;
    t = s;
    for (int b = 0; b < nblk; b++) begin
      row = (b / BITS) % ROWS;
      pl  = b % BITS;
      for (int c = 0; c < COLS; c++) exp_clk_q.push_back({20'(t + 2*c + 3), pixel(row, pl, c)});
      exp_lat_q.push_back({20'(t + 10), 12'h0});
      if (row == 0 && pl == 0) exp_fs_q.push_back({20'(t + 10), 12'h0});
      if (pl == 0) begin
        if (row == 0) begin
          exp_rd_q.push_back({20'(t + 11), 12'h1});
          exp_rd_q.push_back({20'(t + 12), 12'h1});
        end
        exp_rc_q.push_back({20'(t + 12), 12'(row == 0)});
        d = t + 13;
      end else begin
        d = t + 11;
      end
      for (int i = 0; i < (BASE << pl); i++) exp_blk_q.push_back({20'(d + i), 12'h0});
      t = d;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [31:0] e;
    bit          have;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        if (lat === 1'b1) begin
          have = exp_lat_q.size() != 0;
          e = have ? exp_lat_q.pop_front() : '0;
          chk_evt("lat", have, e, 12'h0);
        end
        if (frame_sync === 1'b1) begin
          have = exp_fs_q.size() != 0;
          e = have ? exp_fs_q.pop_front() : '0;
          chk_evt("frame_sync", have, e, 12'h0);
        end
        if (clk_out === 1'b1) begin
          have = exp_clk_q.size() != 0;
          e = have ? exp_clk_q.pop_front() : '0;
          chk_evt("clk_out_rgb", have, e, rgb);
        end
        if (row_clk === 1'b1) begin
          have = exp_rc_q.size() != 0;
          e = have ? exp_rc_q.pop_front() : '0;
          chk_evt("row_clk", have, e, 12'(row_data));
        end
        if (row_data === 1'b1) begin
          have = exp_rd_q.size() != 0;
          e = have ? exp_rd_q.pop_front() : '0;
          chk_evt("row_data", have, e, 12'h1);
        end
        if (blank !== 1'b1) begin
          have = exp_blk_q.size() != 0;
          e = have ? exp_blk_q.pop_front() : '0;
          chk_evt("blank_low", have, e, 12'(blank));
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  initial begin
    int s;
    tests  = 0;
    fails  = 0;
    mon_on = 1'b0;
    rst    = 1'b1;
    en     = 1'b0;

    // Power-on reset.
    repeat (3) @(negedge clk);
    chk_reset_outputs("por");
    rst    = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    // Run A: two frames, en dropped mid second frame -> drain after row 1
    // plane 1 (lat at S+10,23,34,47,58,...,95; IDLE from S+100).
    s = cyc + 1;
    push_run(s, 2 * ROWS * BITS);
    en = 1'b1;
    wait_until(s + 70);
    en = 1'b0;
    wait_until(s + 130);

    // Run B: reset at S+5 -> only the clk_out pulses at S+3 and S+5 occur,
    // and all outputs hold reset values from S+6.
    s = cyc + 1;
    exp_clk_q.push_back({20'(s + 3), pixel(0, 0, 0)});
    exp_clk_q.push_back({20'(s + 5), pixel(0, 0, 1)});
    en = 1'b1;
    wait_until(s + 5);
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst = 1'b0;
    wait_until(s + 45);

    // Run C: one-cycle en pulse -> exactly one frame, then drain and IDLE.
    s = cyc + 1;
    push_run(s, ROWS * BITS);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    wait_until(s + 80);
    chk("idle_blank", 12'(blank), 12'd1);

    chk_empty("lat_missing",   exp_lat_q.size(), (exp_lat_q.size() != 0) ? exp_lat_q[0] : '0);
    chk_empty("fsync_missing", exp_fs_q.size(),  (exp_fs_q.size()  != 0) ? exp_fs_q[0]  : '0);
    chk_empty("clk_missing",   exp_clk_q.size(), (exp_clk_q.size() != 0) ? exp_clk_q[0] : '0);
    chk_empty("rowclk_missing", exp_rc_q.size(), (exp_rc_q.size()  != 0) ? exp_rc_q[0]  : '0);
    chk_empty("rowdata_missing", exp_rd_q.size(), (exp_rd_q.size() != 0) ? exp_rd_q[0]  : '0);
    chk_empty("blank_missing", exp_blk_q.size(), (exp_blk_q.size() != 0) ? exp_blk_q[0] : '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
